// File: rtl/game_input_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : game_input_capture                                              |
// | Purpose  : Button sync/debounce, frame, collision and tick capture feeding |
// |            the memory-mapped game registers r20/r22/r24/r26.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module game_input_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_DIV        = 50000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        btn_jump_raw,
    input  logic        btn_pause_raw,
    input  logic        vsync_pulse,
    input  logic        collision_in,
    output logic [31:0] r20,
    output logic        button_signal_reg,
    output logic [31:0] r22,
    output logic        screen_signal_reg,
    output logic [31:0] r24,
    output logic        collision_signal_reg,
    output logic        pause_signal_reg,
    output logic [31:0] r26
);

    localparam int          c_jump       = 0;
    localparam int          c_pause      = 1;
    localparam logic [16:0] c_deb_target = 17'(DEBOUNCE_CYCLES);
    localparam logic [31:0] c_tick_last  = 32'(TICK_DIV - 1);

    logic [1:0]  w_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_deb;
    logic [1:0]  r_deb_q;
    logic        r_coll_d1;
    logic        r_coll_d2;
    logic [31:0] r_presc;
    logic [31:0] r_frame_cnt;
    logic        w_jump_chg;
    logic        w_pause_rise;
    logic        w_coll_rise;

    assign w_raw = {btn_pause_raw, btn_jump_raw};
    assign r22   = r_frame_cnt;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [15:0] r_cnt;
            logic        r_deb;
            logic [16:0] w_cnt_inc;

            assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
            assign w_deb[gi] = r_deb;

            always_ff @(posedge clock) begin
                if (ctrl_reset) begin
                    r_cnt <= 16'd0;
                    r_deb <= 1'b0;
                end else if (r_sync2[gi] == r_deb) begin
                    r_cnt <= 16'd0;
                end else if (w_cnt_inc == c_deb_target) begin
                    r_deb <= r_sync2[gi];
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= w_cnt_inc[15:0];
                end
            end
        end
    endgenerate

    assign w_jump_chg   = w_deb[c_jump] ^ r_deb_q[c_jump];
    assign w_pause_rise = w_deb[c_pause] & ~r_deb_q[c_pause];
    assign w_coll_rise  = r_coll_d1 & ~r_coll_d2;

    // Frame, collision and timer all qualify on the pause level from before this edge.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_deb_q              <= 2'b00;
            r_coll_d1            <= 1'b0;
            r_coll_d2            <= 1'b0;
            r_presc              <= 32'd0;
            r_frame_cnt          <= 32'd0;
            r20                  <= 32'd0;
            r24                  <= 32'd0;
            r26                  <= 32'd0;
            button_signal_reg    <= 1'b0;
            screen_signal_reg    <= 1'b0;
            collision_signal_reg <= 1'b0;
            pause_signal_reg     <= 1'b0;
        end else begin
            r_deb_q   <= w_deb;
            r_coll_d1 <= collision_in;
            r_coll_d2 <= r_coll_d1;

            button_signal_reg <= w_jump_chg;
            if (w_jump_chg) begin
                r20 <= {31'd0, w_deb[c_jump]};
            end

            if (w_pause_rise) begin
                pause_signal_reg <= ~pause_signal_reg;
            end

            screen_signal_reg <= vsync_pulse & ~pause_signal_reg;
            if (vsync_pulse && !pause_signal_reg) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end

            collision_signal_reg <= w_coll_rise & ~pause_signal_reg;
            if (w_coll_rise && !pause_signal_reg) begin
                r24 <= 32'd1;
            end

            if (!pause_signal_reg) begin
                if (r_presc == c_tick_last) begin
                    r_presc <= 32'd0;
                    r26     <= r26 + 32'd1;
                end else begin
                    r_presc <= r_presc + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
